// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter: registered one-hot and binary grant, a forced idle gap
// between owners, and an optional per-owner hold timeout (MAX_HOLD, 0 = unlimited).
module rr_arbiter_8 #(
  parameter int N_REQ    = 8,
  parameter int IDX_W    = $clog2(N_REQ),
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam int               CNT_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_SAT  = '1;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic             gnt_vld_q;
  logic             timeout_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;

  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             owner_req;
  logic             hold_expired;

  // Scan from the highest offset down so the last hit is the one closest to
  // ptr; N_REQ is a power of two, so the IDX_W-bit sum wraps modulo N_REQ.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    scan_idx = '0;
    win_idx  = '0;
    win_vld  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_idx = ptr_q + IDX_W'(i);
      if (req[scan_idx]) begin
        win_idx = scan_idx;
        win_vld = 1'b1;
      end
    end
  end

  assign owner_req    = req[gnt_idx_q];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  // NOTE: state and registered outputs use non-blocking assignments so every
  // update in this block sees the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          hold_cnt_q <= '0;
          if (win_vld) begin
            state_q   <= ST_GRANT;
            gnt_q     <= N_REQ'(1) << win_idx;
            gnt_idx_q <= win_idx;
            gnt_vld_q <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (hold_cnt_q != HOLD_SAT) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
          // A release always passes through IDLE, giving the one-cycle gnt=0 gap.
          if (!owner_req || hold_expired) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= gnt_idx_q + IDX_W'(1);
            timeout_q <= owner_req;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;

endmodule
